// File: rtl/pipeline_pkg.sv
// Shared types for the MEM1 load/store unit: widths, funct3 encoding and queue entry.
package pipeline_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 64;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } lsu_funct3_e;

  typedef struct packed {
    logic [2:0]  off;
    lsu_funct3_e funct3;
    logic        we;
    logic        fault;
    logic        killed;
  } lsu_entry_t;

  // Encoding 3'b111 is not a legal width; it is treated as byte-aligned.
  function automatic logic is_misaligned(input lsu_funct3_e f3, input logic [2:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W, F3_WU: return |off[1:0];
      F3_D:        return |off;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed lane from a raw doubleword and sign/zero-extends it.
module lsu_load_align
  import pipeline_pkg::*;
(
  input  logic [2:0]            off_i,
  input  lsu_funct3_e           funct3_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_B:    data_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    data_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   data_o = {56'd0, shifted[7:0]};
      F3_HU:   data_o = {48'd0, shifted[15:0]};
      F3_WU:   data_o = {32'd0, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM1 load/store unit: issues accesses to a pipelined data memory and returns
// in-order, extended results through a small circular queue of in-flight accesses.
module mem_lsu_stage
  import pipeline_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  dmem_req_o,
  input  logic                  dmem_gnt_i,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [7:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_misalign_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  lsu_entry_t            entry_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_misalign_q, resp_misalign_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  lsu_funct3_e           req_f3;
  logic                  misalign, full, empty, push, pop, head_killed;
  lsu_entry_t            head, new_entry;
  logic [7:0]            be_base;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_f3   = lsu_funct3_e'(req_funct3_i);
  assign misalign = is_misaligned(req_f3, req_addr_i[2:0]);
  assign full     = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty    = (count_q == '0);
  assign head     = entry_q[rd_ptr_q];

  // Misaligned accesses never reach memory but still take a queue slot so
  // their fault is reported in program order.
  assign dmem_req_o  = rst_ni && req_valid_i && !full && !flush_i && !misalign;
  assign req_ready_o = misalign ? (rst_ni && !full && !flush_i) : (dmem_req_o && dmem_gnt_i);
  assign push        = req_valid_i && req_ready_o;
  assign pop         = !empty && (head.fault || dmem_rvalid_i);
  assign head_killed = head.killed || flush_i;

  always_comb begin
    case (req_f3)
      F3_B, F3_BU: be_base = 8'h01;
      F3_H, F3_HU: be_base = 8'h03;
      F3_W, F3_WU: be_base = 8'h0F;
      default:     be_base = 8'hFF;
    endcase
  end

  assign dmem_we_o    = req_we_i;
  assign dmem_addr_o  = {req_addr_i[ADDR_WIDTH-1:3], 3'b000};
  assign dmem_be_o    = 8'(be_base << req_addr_i[2:0]);
  assign dmem_wdata_o = req_wdata_i << {req_addr_i[2:0], 3'b000};

  assign new_entry = '{off: req_addr_i[2:0], funct3: req_f3, we: req_we_i,
                       fault: misalign, killed: 1'b0};

  lsu_load_align u_align (
    .off_i    (head.off),
    .funct3_i (head.funct3),
    .rdata_i  (dmem_rdata_i),
    .data_o   (load_data)
  );

  always_comb begin
    count_d         = count_q;
    resp_valid_d    = 1'b0;
    resp_misalign_d = 1'b0;
    resp_data_d     = '0;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (pop && !push) count_d = count_q - CNT_W'(1);
    if (pop && !head_killed) begin
      resp_valid_d    = 1'b1;
      resp_misalign_d = head.fault;
      resp_data_d     = (head.we || head.fault) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) entry_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_misalign_q <= 1'b0;
      resp_data_q     <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) entry_q[i].killed <= 1'b1;
      end
      if (push) begin
        entry_q[wr_ptr_q] <= new_entry;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q         <= count_d;
      resp_valid_q    <= resp_valid_d;
      resp_misalign_q <= resp_misalign_d;
      resp_data_q     <= resp_data_d;
    end
  end

  assign resp_valid_o    = resp_valid_q;
  assign resp_misalign_o = resp_misalign_q;
  assign resp_data_o     = resp_data_q;

  // A response with nothing pending at the head is a memory-side protocol error.
  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dmem_rvalid_i |-> (!empty && !head.fault));

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: extension, lanes, faults, back-pressure, flush.
module tb_mem_lsu_stage;
  import pipeline_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [7:0]  dmem_be_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic        resp_valid_o;
  logic [63:0] resp_data_o;
  logic        resp_misalign_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  mem_lsu_stage dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_funct3_i   (req_funct3_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_data_o    (resp_data_o),
    .resp_misalign_o(resp_misalign_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0;
    drive_req(1'b0, 3'b000, 64'h1000, '0);
    #12;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_dmem_req", dmem_req_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_misalign", resp_misalign_o, 0);
    req_valid_i = 1'b0;
    rst_ni = 1'b1;
    tick();

    // LB 0x1003
    drive_req(1'b0, 3'b000, 64'h1003, '0);
    #1;
    chk("lb_dmem_req", dmem_req_o, 1);
    chk("lb_ready", req_ready_o, 1);
    chk("lb_be", dmem_be_o, 64'h08);
    chk("lb_addr", dmem_addr_o, 64'h1000);
    chk("lb_we", dmem_we_o, 0);
    tick();
    req_valid_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h00000000_80FF0000;
    #1;
    chk("lb_no_early_resp", resp_valid_o, 0);
    tick();
    dmem_rvalid_i = 1'b0;
    chk("lb_resp_valid", resp_valid_o, 1);
    chk("lb_resp_data", resp_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_resp_misalign", resp_misalign_o, 0);
    tick();
    chk("lb_resp_pulse", resp_valid_o, 0);

    // LWU 0x1004
    drive_req(1'b0, 3'b110, 64'h1004, '0);
    #1;
    chk("lwu_be", dmem_be_o, 64'hF0);
    tick();
    req_valid_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h89ABCDEF_01234567;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("lwu_resp_valid", resp_valid_o, 1);
    chk("lwu_resp_data", resp_data_o, 64'h0000_0000_89AB_CDEF);

    // SH 0x2006
    drive_req(1'b1, 3'b001, 64'h2006, 64'hBEEF);
    #1;
    chk("sh_be", dmem_be_o, 64'hC0);
    chk("sh_wdata", dmem_wdata_o, 64'hBEEF_0000_0000_0000);
    chk("sh_we", dmem_we_o, 1);
    chk("sh_addr", dmem_addr_o, 64'h2000);
    tick();
    req_valid_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h1234_5678_9ABC_DEF0;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("sh_resp_valid", resp_valid_o, 1);
    chk("sh_resp_data", resp_data_o, 0);

    // LD 0x3000 followed by misaligned LW 0x1002
    drive_req(1'b0, 3'b011, 64'h3000, '0);
    tick();
    drive_req(1'b0, 3'b010, 64'h1002, '0);
    #1;
    chk("mis_no_dmem_req", dmem_req_o, 0);
    chk("mis_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    chk("mis_wait_older0", resp_valid_o, 0);
    tick();
    chk("mis_wait_older1", resp_valid_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h1122_3344_5566_7788;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("ld_resp_valid", resp_valid_o, 1);
    chk("ld_resp_data", resp_data_o, 64'h1122_3344_5566_7788);
    chk("ld_resp_misalign", resp_misalign_o, 0);
    tick();
    chk("mis_resp_valid", resp_valid_o, 1);
    chk("mis_resp_misalign", resp_misalign_o, 1);
    chk("mis_resp_data", resp_data_o, 0);
    tick();
    chk("mis_resp_pulse", resp_valid_o, 0);

    // Three back-to-back LBU 0x4000 with responses held off
    drive_req(1'b0, 3'b100, 64'h4000, '0);
    #1;
    chk("bp_ready0", req_ready_o, 1);
    tick();
    chk("bp_ready1", req_ready_o, 1);
    tick();
    chk("bp_full_ready", req_ready_o, 0);
    chk("bp_full_dmem_req", dmem_req_o, 0);
    tick();
    chk("bp_full_hold", req_ready_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h0000_0000_0000_00FF;
    #1;
    chk("bp_no_bypass", req_ready_o, 0);
    tick();
    dmem_rvalid_i = 1'b0;
    chk("bp_pop1_valid", resp_valid_o, 1);
    chk("bp_pop1_data", resp_data_o, 64'hFF);
    chk("bp_ready_after_pop", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    chk("bp_idle_resp", resp_valid_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h0000_0000_0000_0080;
    tick();
    chk("bp_pop2_data", resp_data_o, 64'h80);
    dmem_rdata_i = 64'h0000_0000_0000_00FE;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("bp_pop3_valid", resp_valid_o, 1);
    chk("bp_pop3_data", resp_data_o, 64'hFE);
    tick();
    chk("bp_drained", resp_valid_o, 0);

    // Flush two queued LD, then a fresh LH
    drive_req(1'b0, 3'b011, 64'h5000, '0);
    tick();
    tick();
    req_valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    chk("flush_silent0", resp_valid_o, 0);
    tick();
    dmem_rvalid_i = 1'b0;
    chk("flush_silent1", resp_valid_o, 0);
    tick();
    chk("flush_silent2", resp_valid_o, 0);
    drive_req(1'b0, 3'b001, 64'h5002, '0);
    #1;
    chk("post_flush_ready", req_ready_o, 1);
    chk("post_flush_be", dmem_be_o, 64'h0C);
    tick();
    req_valid_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h0000_0000_8001_0000;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("post_flush_valid", resp_valid_o, 1);
    chk("post_flush_data", resp_data_o, 64'hFFFF_FFFF_FFFF_8001);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
